// File: rtl/ex_muldiv_pkg.sv
// Shared constants and helpers for the RV32M multiply/divide unit in EX.
// Operand width, register-address width and funct3 encodings live here.
package ex_muldiv_pkg;

    localparam int RDATA_WIDTH = 32;
    localparam int RADDR_WIDTH = 5;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    localparam logic                   WRITE_ENABLE = 1'b1;
    localparam logic [RADDR_WIDTH-1:0] ZERO_REG     = 5'd0;

    // Conditional two's-complement negation, used for magnitudes and sign fix-up.
    function automatic logic [RDATA_WIDTH-1:0] twos_neg(input logic [RDATA_WIDTH-1:0] v,
                                                        input logic                   en);
        logic [RDATA_WIDTH-1:0] r;
        if (en) begin
            r = ~v + {{(RDATA_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/ex_div_core.sv
// Iterative restoring divider on unsigned magnitudes: one quotient bit per cycle.
// quot/rem carry the final step's result combinationally while done is high.
module ex_div_core #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            flush,
    output logic            done,
    output logic [XLEN-1:0] quot,
    output logic [XLEN-1:0] rem
);

    localparam int CW = $clog2(XLEN);

    logic            busy_r;
    logic [CW-1:0]   cnt_r;
    logic [XLEN-1:0] dvd_r;
    logic [XLEN-1:0] dvs_r;
    logic [XLEN-1:0] rem_r;

    logic [XLEN:0]   shift_s;
    logic            qbit_s;
    logic [XLEN-1:0] rem_n_s;

    // One restoring step: shift in the next dividend bit and subtract if it fits.
    always_comb begin
        shift_s = {rem_r, dvd_r[XLEN-1]};
        qbit_s  = shift_s[XLEN] | (shift_s[XLEN-1:0] >= dvs_r);
        if (qbit_s) begin
            rem_n_s = shift_s[XLEN-1:0] - dvs_r;
        end else begin
            rem_n_s = shift_s[XLEN-1:0];
        end
    end

    assign done = busy_r & (cnt_r == {CW{1'b0}});
    assign quot = {dvd_r[XLEN-2:0], qbit_s};
    assign rem  = rem_n_s;

    // Iteration state; dvd_r turns into the quotient as its bits shift out.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            busy_r <= 1'b0;
            cnt_r  <= {CW{1'b0}};
            dvd_r  <= {XLEN{1'b0}};
            dvs_r  <= {XLEN{1'b0}};
            rem_r  <= {XLEN{1'b0}};
        end else if (start) begin
            busy_r <= 1'b1;
            cnt_r  <= CW'(XLEN - 1);
            dvd_r  <= dividend;
            dvs_r  <= divisor;
            rem_r  <= {XLEN{1'b0}};
        end else if (busy_r) begin
            dvd_r  <= {dvd_r[XLEN-2:0], qbit_s};
            rem_r  <= rem_n_s;
            cnt_r  <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
            busy_r <= ~done;
        end else begin
            busy_r <= busy_r;
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// RV32M multiply/divide unit in EX: stalls the pipeline while working and
// returns one registered writeback beat per accepted op.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN = RDATA_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic [2:0]             funct3_i,
    input  logic [XLEN-1:0]        op1_i,
    input  logic [XLEN-1:0]        op2_i,
    input  logic [RADDR_WIDTH-1:0] waddr_i,
    input  logic                   flush_i,
    output logic                   stall_req_o,
    output logic                   busy_o,
    output logic                   valid_o,
    output logic [XLEN-1:0]        result_o,
    output logic                   reg_we_o,
    output logic [RADDR_WIDTH-1:0] reg_waddr_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] ZERO_W   = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    state_t                 state_r, state_n;
    logic [2:0]             funct3_r;
    logic [XLEN-1:0]        op1_r, op2_r;
    logic [RADDR_WIDTH-1:0] waddr_r;
    logic                   valid_r, valid_n;
    logic [XLEN-1:0]        result_r, result_n;
    logic [RADDR_WIDTH-1:0] out_waddr_r, out_waddr_n;

    logic                   accept_s;
    logic                   ovf_s;
    logic                   div_start_s;
    logic                   div_signed_s;
    logic                   div_done_s;
    logic [XLEN-1:0]        div_quot_s, div_rem_s;
    logic                   a_sign_s, b_sign_s;
    logic [2*XLEN-1:0]      prod_s;
    logic [XLEN-1:0]        mul_res_s;
    logic [XLEN-1:0]        div_res_s;

    assign accept_s     = (state_r == ST_IDLE) & start_i & ~flush_i;
    assign div_signed_s = ~funct3_i[0];
    assign ovf_s        = div_signed_s & (op1_i == INT_MIN) & (op2_i == ALL_ONES);

    ex_div_core #(.XLEN(XLEN)) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start_s),
        .dividend (twos_neg(op1_i, div_signed_s & op1_i[XLEN-1])),
        .divisor  (twos_neg(op2_i, div_signed_s & op2_i[XLEN-1])),
        .flush    (flush_i),
        .done     (div_done_s),
        .quot     (div_quot_s),
        .rem      (div_rem_s)
    );

    // Operand extension per multiply flavour; the low product word is sign-agnostic.
    always_comb begin
        a_sign_s = 1'b0;
        b_sign_s = 1'b0;
        case (funct3_r)
            MD_MULH: begin
                a_sign_s = op1_r[XLEN-1];
                b_sign_s = op2_r[XLEN-1];
            end
            MD_MULHSU: a_sign_s = op1_r[XLEN-1];
            default:   a_sign_s = 1'b0;
        endcase
        prod_s = {{XLEN{a_sign_s}}, op1_r} * {{XLEN{b_sign_s}}, op2_r};
        if (funct3_r == MD_MUL) begin
            mul_res_s = prod_s[XLEN-1:0];
        end else begin
            mul_res_s = prod_s[2*XLEN-1:XLEN];
        end
    end

    // Sign fix-up: quotient negative iff signs differ, remainder follows the dividend.
    always_comb begin
        case (funct3_r)
            MD_DIV:  div_res_s = twos_neg(div_quot_s, op1_r[XLEN-1] ^ op2_r[XLEN-1]);
            MD_DIVU: div_res_s = div_quot_s;
            MD_REM:  div_res_s = twos_neg(div_rem_s, op1_r[XLEN-1]);
            MD_REMU: div_res_s = div_rem_s;
            default: div_res_s = ZERO_W;
        endcase
    end

    // Next-state and next writeback beat; the beat is registered on entry to DONE.
    always_comb begin
        state_n     = state_r;
        valid_n     = 1'b0;
        result_n    = ZERO_W;
        out_waddr_n = ZERO_REG;
        div_start_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!accept_s) begin
                    state_n = ST_IDLE;
                end else if (!funct3_i[2]) begin
                    state_n = ST_MUL;
                end else if (op2_i == ZERO_W) begin
                    state_n     = ST_DONE;
                    valid_n     = 1'b1;
                    result_n    = funct3_i[1] ? op1_i : ALL_ONES;
                    out_waddr_n = waddr_i;
                end else if (ovf_s) begin
                    state_n     = ST_DONE;
                    valid_n     = 1'b1;
                    result_n    = funct3_i[1] ? ZERO_W : op1_i;
                    out_waddr_n = waddr_i;
                end else begin
                    state_n     = ST_DIV;
                    div_start_s = 1'b1;
                end
            end
            ST_MUL: begin
                if (flush_i) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n     = ST_DONE;
                    valid_n     = 1'b1;
                    result_n    = mul_res_s;
                    out_waddr_n = waddr_r;
                end
            end
            ST_DIV: begin
                if (flush_i) begin
                    state_n = ST_IDLE;
                end else if (div_done_s) begin
                    state_n     = ST_DONE;
                    valid_n     = 1'b1;
                    result_n    = div_res_s;
                    out_waddr_n = waddr_r;
                end else begin
                    state_n = ST_DIV;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // State, latched operands and the registered writeback beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            funct3_r    <= 3'b000;
            op1_r       <= ZERO_W;
            op2_r       <= ZERO_W;
            waddr_r     <= ZERO_REG;
            valid_r     <= 1'b0;
            result_r    <= ZERO_W;
            out_waddr_r <= ZERO_REG;
        end else begin
            state_r     <= state_n;
            valid_r     <= valid_n;
            result_r    <= result_n;
            out_waddr_r <= out_waddr_n;
            if (accept_s) begin
                funct3_r <= funct3_i;
                op1_r    <= op1_i;
                op2_r    <= op2_i;
                waddr_r  <= waddr_i;
            end else if (flush_i) begin
                funct3_r <= 3'b000;
                op1_r    <= ZERO_W;
                op2_r    <= ZERO_W;
                waddr_r  <= ZERO_REG;
            end else begin
                funct3_r <= funct3_r;
            end
        end
    end

    assign valid_o     = valid_r;
    assign reg_we_o    = valid_r & WRITE_ENABLE;
    assign result_o    = result_r;
    assign reg_waddr_o = out_waddr_r;
    assign busy_o      = (state_r != ST_IDLE);
    assign stall_req_o = ((state_r == ST_IDLE) & start_i) | (state_r == ST_MUL) | (state_r == ST_DIV);

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed cases plus randomized ops checked
// against an arithmetic reference model of the RV32M rules.
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic [2:0]  funct3_i = 3'b000;
    logic [31:0] op1_i = 32'd0;
    logic [31:0] op2_i = 32'd0;
    logic [4:0]  waddr_i = 5'd0;
    logic        flush_i = 1'b0;
    logic        stall_req_o, busy_o, valid_o, reg_we_o;
    logic [31:0] result_o;
    logic [4:0]  reg_waddr_o;

    int n_checks = 0;
    int n_fail   = 0;

    ex_muldiv dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .funct3_i    (funct3_i),
        .op1_i       (op1_i),
        .op2_i       (op2_i),
        .waddr_i     (waddr_i),
        .flush_i     (flush_i),
        .stall_req_o (stall_req_o),
        .busy_o      (busy_o),
        .valid_o     (valid_o),
        .result_o    (result_o),
        .reg_we_o    (reg_we_o),
        .reg_waddr_o (reg_waddr_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub, p;
        logic [31:0]     r;
        logic            ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: begin p = ua * ub; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * longint'(ub); r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: r = (b == 32'd0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
            3'd5: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: r = (b == 32'd0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
            default: r = (b == 32'd0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b);
        if (!f3[2]) return 2;
        if (b == 32'd0) return 1;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    // Issues one op and observes 45 cycles: first beat, beat count, stall cycles, stray outputs.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output int lat, output logic [31:0] res,
                         output logic [4:0] wa, output int beats, output int stalls,
                         output int junk);
        lat = 0; res = 32'd0; wa = 5'd0; beats = 0; stalls = 0; junk = 0;
        @(negedge clk);
        start_i = 1'b1; funct3_i = f3; op1_i = a; op2_i = b; waddr_i = rd;
        for (int k = 0; k < 45; k++) begin
            if (k == 1) start_i = 1'b0;
            #1;
            if (stall_req_o) stalls++;
            if (valid_o) begin
                beats++;
                if (lat == 0) begin lat = k; res = result_o; wa = reg_waddr_o; end
            end
            if (reg_we_o !== valid_o) junk++;
            if (!valid_o && (result_o !== 32'd0 || reg_waddr_o !== 5'd0)) junk++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b0; flush_i = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if ({valid_o, reg_we_o, busy_o, stall_req_o} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl got %b required 0000", {valid_o, reg_we_o, busy_o, stall_req_o});
        end
        n_checks++;
        if (result_o !== 32'd0 || reg_waddr_o !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_data got %h/%0d required 0/0", result_o, reg_waddr_o);
        end
        rst = 1'b0;
    endtask

    // Shared by the directed tables: f3, a, b, expected result, expected latency.
    task automatic test_table(input string name, input logic [2:0] f3s[4], input logic [31:0] as_[4],
                              input logic [31:0] bs[4], input logic [31:0] exps[4], input int lats[4]);
        int lat, beats, stalls, junk;
        logic [31:0] res;
        logic [4:0]  wa;
        for (int i = 0; i < 4; i++) begin
            issue(f3s[i], as_[i], bs[i], 5'(5 + i), lat, res, wa, beats, stalls, junk);
            n_checks++;
            if (res !== exps[i] || lat != lats[i] || beats != 1) begin
                n_fail++;
                $display("FAIL %s[%0d] got res=%h lat=%0d beats=%0d required res=%h lat=%0d beats=1",
                         name, i, res, lat, beats, exps[i], lats[i]);
            end
            n_checks++;
            if (wa !== 5'(5 + i) || stalls != lats[i] || junk != 0) begin
                n_fail++;
                $display("FAIL %s_ctl[%0d] got rd=%0d stalls=%0d junk=%0d required rd=%0d stalls=%0d junk=0",
                         name, i, wa, stalls, junk, 5 + i, lats[i]);
            end
        end
    endtask

    task automatic test_mul();
        test_table("mul", '{3'd0, 3'd1, 3'd2, 3'd3},
                   '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
                   '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
                   '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
                   '{2, 2, 2, 2});
    endtask

    task automatic test_div();
        test_table("div", '{3'd4, 3'd6, 3'd5, 3'd7},
                   '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100},
                   '{32'd2, 32'd2, 32'd7, 32'd7},
                   '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2},
                   '{33, 33, 33, 33});
    endtask

    task automatic test_div_special();
        test_table("divsp", '{3'd5, 3'd6, 3'd4, 3'd6},
                   '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000},
                   '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
                   '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0},
                   '{1, 1, 1, 1});
    endtask

    task automatic test_random();
        int lat, beats, stalls, junk, exp_lat;
        logic [31:0] res, a, b, exp_res;
        logic [4:0]  wa, rd;
        logic [2:0]  f3;
        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = pick_operand();
            b  = pick_operand();
            rd = 5'($urandom_range(0, 31));
            exp_res = ref_result(f3, a, b);
            exp_lat = ref_latency(f3, a, b);
            issue(f3, a, b, rd, lat, res, wa, beats, stalls, junk);
            n_checks++;
            if (res !== exp_res || lat != exp_lat || beats != 1) begin
                n_fail++;
                $display("FAIL rand[%0d] f3=%0d a=%h b=%h got res=%h lat=%0d beats=%0d required res=%h lat=%0d beats=1",
                         i, f3, a, b, res, lat, beats, exp_res, exp_lat);
            end
            n_checks++;
            if (wa !== rd || stalls != exp_lat || junk != 0) begin
                n_fail++;
                $display("FAIL rand_ctl[%0d] got rd=%0d stalls=%0d junk=%0d required rd=%0d stalls=%0d junk=0",
                         i, wa, stalls, junk, rd, exp_lat);
            end
        end
    endtask

    // Abort a divide at t+10 by flush or reset, then run a MUL from t+11.
    task automatic test_abort(input bit use_rst);
        int ghost = 0;
        logic [31:0] a2, b2;
        @(negedge clk);
        start_i = 1'b1; funct3_i = 3'd4; op1_i = 32'd1000; op2_i = 32'd3; waddr_i = 5'd7;
        for (int k = 1; k < 10; k++) begin
            @(negedge clk);
            start_i = 1'b0;
            if (valid_o) ghost++;
        end
        @(negedge clk);
        if (use_rst) rst = 1'b1; else flush_i = 1'b1;
        if (valid_o) ghost++;
        @(negedge clk);
        rst = 1'b0; flush_i = 1'b0;
        #1;
        n_checks++;
        if (busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_busy(rst=%0d) got %b required 0", use_rst, busy_o);
        end
        if (use_rst) begin
            n_checks++;
            if ({valid_o, reg_we_o, stall_req_o} !== 3'b000 || result_o !== 32'd0 || reg_waddr_o !== 5'd0) begin
                n_fail++;
                $display("FAIL rst_outputs got v=%b we=%b st=%b res=%h rd=%0d required all 0",
                         valid_o, reg_we_o, stall_req_o, result_o, reg_waddr_o);
            end
        end
        a2 = $urandom; b2 = $urandom;
        start_i = 1'b1; funct3_i = 3'd0; op1_i = a2; op2_i = b2; waddr_i = 5'd9;
        @(negedge clk);
        start_i = 1'b0;
        if (valid_o) ghost++;
        @(negedge clk);
        n_checks++;
        if (valid_o !== 1'b1 || result_o !== ref_result(3'd0, a2, b2) || reg_waddr_o !== 5'd9) begin
            n_fail++;
            $display("FAIL abort_mul(rst=%0d) got v=%b res=%h rd=%0d required v=1 res=%h rd=9",
                     use_rst, valid_o, result_o, reg_waddr_o, ref_result(3'd0, a2, b2));
        end
        for (int k = 14; k < 46; k++) begin
            @(negedge clk);
            if (valid_o) ghost++;
        end
        n_checks++;
        if (ghost != 0) begin
            n_fail++;
            $display("FAIL abort_ghost(rst=%0d) got %0d stray beats required 0", use_rst, ghost);
        end
    endtask

    // start_i held for 40 cycles: one beat at t+33, re-accept at t+34, second beat at t+67.
    task automatic test_back_to_back();
        int beats = 0, first = -1, second = -1;
        logic [31:0] r1 = 32'd0, r2 = 32'd0;
        @(negedge clk);
        start_i = 1'b1; funct3_i = 3'd5; op1_i = 32'd1000; op2_i = 32'd7; waddr_i = 5'd3;
        for (int k = 0; k < 80; k++) begin
            #1;
            if (valid_o) begin
                beats++;
                if (first < 0) begin first = k; r1 = result_o; end
                else begin second = k; r2 = result_o; end
            end
            if (k == 35) begin
                n_checks++;
                if (busy_o !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_reaccept got busy=%b required 1", busy_o);
                end
            end
            if (k == 39) start_i = 1'b0;
            @(negedge clk);
        end
        n_checks++;
        if (beats != 2 || first != 33 || second != 67) begin
            n_fail++;
            $display("FAIL b2b_timing got beats=%0d first=%0d second=%0d required 2/33/67",
                     beats, first, second);
        end
        n_checks++;
        if (r1 !== 32'd142 || r2 !== 32'd142) begin
            n_fail++;
            $display("FAIL b2b_result got %h/%h required 8e/8e", r1, r2);
        end
    endtask

    task automatic test_flush_start();
        int beats = 0;
        @(negedge clk);
        start_i = 1'b1; flush_i = 1'b1; funct3_i = 3'd0; op1_i = 32'd3; op2_i = 32'd4; waddr_i = 5'd1;
        @(negedge clk);
        start_i = 1'b0; flush_i = 1'b0;
        #1;
        n_checks++;
        if (busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_start_busy got %b required 0", busy_o);
        end
        for (int k = 0; k < 5; k++) begin
            if (valid_o) beats++;
            @(negedge clk);
        end
        n_checks++;
        if (beats != 0) begin
            n_fail++;
            $display("FAIL flush_start_beats got %0d required 0", beats);
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div_special();
        test_abort(1'b0);
        test_abort(1'b1);
        test_back_to_back();
        test_flush_start();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
